sevenseg_scan8: RTL
===================

Name: sevenseg_scan8

Overview:
- Consumer of the 32-bit register word from the register-select block.
- Displays the word as 8 hex digits on the board's multiplexed, common-anode seven-segment display.
- Time-multiplexes one digit at a time at a programmable rate, with an anti-ghosting blank interval at each digit change.
- Latches the input word only at frame boundaries, so a word change never tears mid-scan.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 4..2^24.
- BLANK_CYC, 4, cycles at the start of each slot with all anodes off; legal range 0..REFRESH_DIV-2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- data_reg  in  32  word to display; nibble k shown on digit k
- en  in  1  1 = scan and display; 0 = display dark, scan frozen
- dp_mask  in  8  decimal point per digit, 1 = lit; sampled with data_reg
- an  out  8  digit anodes, active-low, one-hot-low when lit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse when a new word is latched

Behaviour:
Reset (async, rst=1):
- an=8'hFF, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler pcnt=0, digit index idx=0, shadow word and mask = 0.
- load_pending=1.

Prescaler:
- pcnt counts 0..REFRESH_DIV-1 while en=1, then wraps to 0.
- Width is $clog2(REFRESH_DIV).
- Terminal count (pcnt==REFRESH_DIV-1): idx <= idx+1, 3-bit, wraps 7->0.

Shadow latch:
- Loads data_reg/dp_mask on the terminal-count cycle with idx==7, i.e. frame end.
- Also loads on the first en=1 cycle while load_pending=1; load_pending then clears.
- frame_tick=1 in the cycle after each load, otherwise 0.
- Changes to data_reg between loads have no visible effect.

Output stage (registered, 1 cycle after idx/pcnt/shadow):
- If en=0 or pcnt<BLANK_CYC: an=8'hFF, seg=7'h7F, dp=1.
- Else: an = ~(1<<idx); seg = decode(shadow[4*idx+3 -: 4]); dp = ~shadow_mask[idx].

Decode (active-low gfedcba, hex):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E

en=0:
- pcnt, idx and shadow hold.
- Outputs go dark on the next cycle.
- Scan resumes from the held pcnt/idx.

Reset mid-scan: all state returns to reset values immediately, outputs included, asynchronously.

Simultaneous events: a frame-end latch and a data_reg change in the same cycle capture the data_reg value present in that cycle.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Compute msd = index of the highest nonzero nibble of the shadow word; msd=0 if the word is 0.
  - Digits with idx>msd are blanked: an=8'hFF, seg=7'h7F, dp=1, regardless of dp_mask.
  - Digit 0 is always shown, so word 0 displays "0".
  - msd is registered with the shadow load.
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
1. Reset release, en=1, data_reg=32'h0000_0000, REFRESH_DIV=8, BLANK_CYC=2 -> frame_tick pulses once; digit 0 has an=FE, seg=40; an=FF during pcnt 0..1 of each slot.
2. data_reg=32'h89AB_CDEF, dp_mask=8'h01 -> across one frame, (an,seg) = (FE,0E), (FD,06), (FB,21), (F7,46), (EF,03), (DF,08), (BF,10), (7F,00); dp=0 only on digit 0.
3. Change data_reg to 32'h1234_5678 mid-frame (idx=3) -> digits 3..7 still show the old word; new word is visible from next frame's digit 0; frame_tick pulses exactly at the wrap.
4. en=0 for 20 cycles at idx=5, pcnt=4 -> an=FF within 1 cycle; on en=1, idx=5 and pcnt resume from 4.
5. Assert rst at idx=6 -> an=FF, seg=7F, dp=1 immediately, without waiting for a clk edge; idx=0 after release.
6. With LEADING_ZERO_BLANK_EN: data_reg=32'h0000_00A5 -> only an=FE (seg=12) and an=FD (seg=08) light; data_reg=0 -> only digit 0 lit, seg=40.

Source files
------------

// File: rtl/sevenseg_scan8_if.sv
// Bus between the register-select block (master) and the eight-digit
// seven-segment scanner (slave). The master drives the word and controls.
// The slave drives the anode, segment and decimal-point lines, plus the
// frame pulse.
interface sevenseg_scan8_if;
    logic [31:0] data_reg;    // word to display, nibble k on digit k
    logic        en;          // 1 = scan and display, 0 = dark and frozen
    logic [7:0]  dp_mask;     // decimal point per digit, 1 = lit
    logic [7:0]  an;          // digit anodes, active-low
    logic [6:0]  seg;         // segments {g,f,e,d,c,b,a}, active-low
    logic        dp;          // decimal point, active-low
    logic        frame_tick;  // one-cycle pulse after a new word is latched

    modport master (
        output data_reg, en, dp_mask,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  data_reg, en, dp_mask,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan8.sv
// Eight-digit multiplexed driver for a common-anode seven-segment display.
// - Shows a 32-bit word as hex, one digit per REFRESH_DIV-cycle slot.
// - Blanks all anodes for the first BLANK_CYC cycles of each slot to
//   prevent ghosting.
// - The word and the dp mask are shadowed at frame boundaries only, so
//   a display frame never tears.
// - Parameter ranges: REFRESH_DIV 4..2^24, BLANK_CYC 0..REFRESH_DIV-2.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank the leading-zero
// digits above the most significant nonzero nibble. Digit 0 is always shown.
module sevenseg_scan8 #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    sevenseg_scan8_if.slave  bus
);

    localparam int unsigned     PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0]   PCNT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYC);

    // Active-low gfedcba pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan state
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [7:0]    mask_q, mask_d;
    logic          load_pending_q, load_pending_d;

    // Registered outputs
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;

    logic          term_cnt;
    logic          load;
    logic          in_blank;
    logic          dark;
    logic [3:0]    cur_nib;

`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0]    msd_q, msd_d;
    logic          above_msd;

    // Index of the highest nonzero nibble, 0 when the word is zero.
    function automatic logic [2:0] msd_of(input logic [31:0] w);
        logic [2:0] m;
        m = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (w[4*k +: 4] != 4'h0) m = 3'(k);
        end
        return m;
    endfunction
`endif

    // Slot blanking window; a zero-length window is never active.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            always_comb in_blank = 1'b0;
        end else begin : g_blank
            always_comb in_blank = (pcnt_q < BLANK_END);
        end
    endgenerate

    // Prescaler, digit index and frame-boundary shadow load.
    always_comb begin
        pcnt_d         = pcnt_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        mask_d         = mask_q;
        load_pending_d = load_pending_q;
        term_cnt       = (pcnt_q == PCNT_LAST);
        load           = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        msd_d          = msd_q;
`endif
        if (bus.en) begin
            pcnt_d = term_cnt ? '0 : pcnt_q + 1'b1;
            if (term_cnt) idx_d = idx_q + 3'd1;
            load = load_pending_q || (term_cnt && (idx_q == 3'd7));
        end
        if (load) begin
            shadow_d       = bus.data_reg;
            mask_d         = bus.dp_mask;
            load_pending_d = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            msd_d          = msd_of(bus.data_reg);
`endif
        end
        frame_tick_d = load;
    end

    // Output stage: decode the current slot, dark while disabled or blanking.
    always_comb begin
        cur_nib = shadow_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        above_msd = (idx_q > msd_q);
        dark      = !bus.en || in_blank || above_msd;
`else
        dark      = !bus.en || in_blank;
`endif
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (!dark) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = hex_decode(cur_nib);
            dp_d  = ~mask_q[idx_q];
        end
    end

    // All state and outputs, asynchronously reset to a dark display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q         <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            mask_q         <= '0;
            load_pending_q <= 1'b1;
            an_q           <= '1;
            seg_q          <= '1;
            dp_q           <= 1'b1;
            frame_tick_q   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            msd_q          <= '0;
`endif
        end else begin
            pcnt_q         <= pcnt_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            mask_q         <= mask_d;
            load_pending_q <= load_pending_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_tick_q   <= frame_tick_d;
`ifdef LEADING_ZERO_BLANK_EN
            msd_q          <= msd_d;
`endif
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
